// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with IF/ID latch, regfile, load-use hazard detection and ID/EX register.
// Optional macro ID_RF_BYPASS_EN enables write-through bypass of same-cycle writeback on register reads.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc_plus4,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc_plus4,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_alu_src
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
  } idex_t;
  logic [31:0]     fd_instr_q, fd_instr_d;
  logic [XLEN-1:0] fd_pc_q, fd_pc_d, fd_pc4_q, fd_pc4_d;
  logic            fd_valid_q, fd_valid_d;
  logic [XLEN-1:0] rf_q [NREG];
  idex_t           idex_q, idex_d;
  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic            is_r, is_opi, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, known;
  logic            use1, use2, bubble;
  logic [XLEN-1:0] imm, rs1_data, rs2_data;
  assign opc      = fd_instr_q[6:0];
  assign rd       = fd_instr_q[11:7];
  assign rs1      = fd_instr_q[19:15];
  assign rs2      = fd_instr_q[24:20];
  assign is_r     = opc == 7'b0110011;
  assign is_opi   = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign known    = is_r | is_opi | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
  assign use1     = is_r | is_opi | is_ld | is_st | is_br | is_jalr;
  assign use2     = is_r | is_st | is_br;
  always_comb begin
    imm = (is_opi | is_ld | is_jalr) ? {{(XLEN-12){fd_instr_q[31]}}, fd_instr_q[31:20]} :
          is_st ? {{(XLEN-12){fd_instr_q[31]}}, fd_instr_q[31:25], fd_instr_q[11:7]} :
          is_br ? {{(XLEN-12){fd_instr_q[31]}}, fd_instr_q[7], fd_instr_q[30:25], fd_instr_q[11:8], 1'b0} :
          (is_lui | is_auipc) ? {{(XLEN-32){fd_instr_q[31]}}, fd_instr_q[31:12], 12'b0} :
          is_jal ? {{(XLEN-20){fd_instr_q[31]}}, fd_instr_q[19:12], fd_instr_q[20], fd_instr_q[30:21], 1'b0} :
          '0;
  end
`ifdef ID_RF_BYPASS_EN
  assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_we && wb_rd == rs1) ? wb_data : rf_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_we && wb_rd == rs2) ? wb_data : rf_q[rs2];
`else
  assign rs1_data = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`endif
  assign hazard_stall = !rst && !flush && idex_q.valid && idex_q.mem_read && idex_q.rd != 5'd0 && fd_valid_q &&
                        ((use1 && idex_q.rd == rs1) || (use2 && idex_q.rd == rs2));
  always_comb begin
    fd_instr_d = (rst || flush) ? '0 : hazard_stall ? fd_instr_q : if_instr;
    fd_valid_d = (rst || flush) ? 1'b0 : hazard_stall ? fd_valid_q : (if_instr != 32'd0);
    fd_pc_d    = rst ? '0 : hazard_stall ? fd_pc_q : if_pc;
    fd_pc4_d   = rst ? '0 : hazard_stall ? fd_pc4_q : if_pc_plus4;
  end
  // Unrecognised opcodes leave ID/EX as a full bubble, same as a killed slot.
  assign bubble = rst || flush || hazard_stall || !fd_valid_q || !known;
  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.valid     = 1'b1;
      idex_d.pc        = fd_pc_q;
      idex_d.pc4       = fd_pc4_q;
      idex_d.rs1_data  = rs1_data;
      idex_d.rs2_data  = rs2_data;
      idex_d.imm       = imm;
      idex_d.rs1       = rs1;
      idex_d.rs2       = rs2;
      idex_d.rd        = rd;
      idex_d.opcode    = opc;
      idex_d.funct3    = fd_instr_q[14:12];
      idex_d.funct7b5  = fd_instr_q[30];
      idex_d.reg_write = !(is_st || is_br) && rd != 5'd0;
      idex_d.mem_read  = is_ld;
      idex_d.mem_write = is_st;
      idex_d.branch    = is_br;
      idex_d.jump      = is_jal || is_jalr;
      idex_d.alu_src   = !(is_r || is_br);
    end
  end
  always_ff @(posedge clk) begin
    fd_instr_q <= fd_instr_d;
    fd_valid_q <= fd_valid_d;
    fd_pc_q    <= fd_pc_d;
    fd_pc4_q   <= fd_pc4_d;
    idex_q     <= idex_d;
    if (wb_we && wb_rd != 5'd0) rf_q[wb_rd] <= wb_data;
  end
  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_pc_plus4  = idex_q.pc4;
  assign ex_rs1_data  = idex_q.rs1_data;
  assign ex_rs2_data  = idex_q.rs2_data;
  assign ex_imm       = idex_q.imm;
  assign ex_rs1       = idex_q.rs1;
  assign ex_rs2       = idex_q.rs2;
  assign ex_rd        = idex_q.rd;
  assign ex_opcode    = idex_q.opcode;
  assign ex_funct3    = idex_q.funct3;
  assign ex_funct7b5  = idex_q.funct7b5;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_branch    = idex_q.branch;
  assign ex_jump      = idex_q.jump;
  assign ex_alu_src   = idex_q.alu_src;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage; expectations follow ID_RF_BYPASS_EN when defined.
module tb_id_stage;
  logic        clk, rst, flush, wb_we;
  logic [31:0] if_pc, if_instr, if_pc_plus4, wb_data;
  logic [4:0]  wb_rd;
  logic        hazard_stall, ex_valid, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src;
  logic [31:0] ex_pc, ex_pc_plus4, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  int n_cmp = 0;
  int n_bad = 0;
  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_alu_src(ex_alu_src)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    if_instr = ins;
    if_pc = pc;
    if_pc_plus4 = pc + 32'd4;
    tick();
    if_instr = 32'd0;
    tick();
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %h want 0", ex_valid); end
    n_cmp++; if ({ex_pc, ex_imm, ex_rd, ex_opcode} !== '0) begin n_bad++; $display("FAIL reset_data got %h %h %h %h want 0", ex_pc, ex_imm, ex_rd, ex_opcode); end
    n_cmp++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src} !== 6'd0) begin n_bad++; $display("FAIL reset_ctrl got %b want 0", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src}); end
    n_cmp++; if (hazard_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %h want 0", hazard_stall); end
  endtask
  task automatic test_addi;
    issue(32'h00500093, 32'h100);
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid got %h want 1", ex_valid); end
    n_cmp++; if (ex_rd !== 5'd1) begin n_bad++; $display("FAIL addi_rd got %h want 1", ex_rd); end
    n_cmp++; if (ex_imm !== 32'd5) begin n_bad++; $display("FAIL addi_imm got %h want 5", ex_imm); end
    n_cmp++; if ({ex_alu_src, ex_reg_write, ex_mem_read, ex_jump} !== 4'b1100) begin n_bad++; $display("FAIL addi_ctrl got %b want 1100", {ex_alu_src, ex_reg_write, ex_mem_read, ex_jump}); end
    n_cmp++; if ({ex_pc, ex_pc_plus4} !== {32'h100, 32'h104}) begin n_bad++; $display("FAIL addi_pc got %h %h want 100 104", ex_pc, ex_pc_plus4); end
    n_cmp++; if (ex_opcode !== 7'b0010011) begin n_bad++; $display("FAIL addi_opcode got %b want 0010011", ex_opcode); end
  endtask
  task automatic test_load_use;
    if_instr = 32'h0000A103;
    tick();
    if_instr = 32'h001101B3;
    tick();
    n_cmp++; if (hazard_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall_on got %h want 1", hazard_stall); end
    n_cmp++; if ({ex_valid, ex_mem_read, ex_rd} !== {2'b11, 5'd2}) begin n_bad++; $display("FAIL lu_load_ex got %b %b %h want 1 1 2", ex_valid, ex_mem_read, ex_rd); end
    if_instr = 32'd0;
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got %h want 0", ex_valid); end
    n_cmp++; if (hazard_stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_off got %h want 0", hazard_stall); end
    tick();
    n_cmp++; if ({ex_valid, ex_rs1, ex_rs2, ex_rd} !== {1'b1, 5'd2, 5'd1, 5'd3}) begin n_bad++; $display("FAIL lu_add got %h %h %h %h want 1 2 1 3", ex_valid, ex_rs1, ex_rs2, ex_rd); end
    n_cmp++; if ({ex_reg_write, ex_alu_src, ex_mem_read} !== 3'b100) begin n_bad++; $display("FAIL lu_add_ctrl got %b want 100", {ex_reg_write, ex_alu_src, ex_mem_read}); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_drain got %h want 0", ex_valid); end
  endtask
  task automatic test_imm_types;
    issue(32'hFE208CE3, 32'h200);
    n_cmp++; if ({ex_valid, ex_branch, ex_reg_write, ex_alu_src} !== 4'b1100) begin n_bad++; $display("FAIL beq_ctrl got %b want 1100", {ex_valid, ex_branch, ex_reg_write, ex_alu_src}); end
    n_cmp++; if (ex_imm !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL beq_imm got %h want fffffff8", ex_imm); end
    issue(32'h0020A623, 32'h204);
    n_cmp++; if ({ex_mem_write, ex_reg_write, ex_alu_src, ex_funct3} !== 6'b101010) begin n_bad++; $display("FAIL sw_ctrl got %b want 101010", {ex_mem_write, ex_reg_write, ex_alu_src, ex_funct3}); end
    n_cmp++; if (ex_imm !== 32'd12) begin n_bad++; $display("FAIL sw_imm got %h want c", ex_imm); end
    issue(32'hABCDE4B7, 32'h208);
    n_cmp++; if ({ex_imm, ex_rd, ex_reg_write} !== {32'hABCDE000, 5'd9, 1'b1}) begin n_bad++; $display("FAIL lui got %h %h %h want abcde000 9 1", ex_imm, ex_rd, ex_reg_write); end
    issue(32'hFFDFF0EF, 32'h20C);
    n_cmp++; if ({ex_imm, ex_jump, ex_reg_write} !== {32'hFFFFFFFC, 2'b11}) begin n_bad++; $display("FAIL jal got %h %h %h want fffffffc 1 1", ex_imm, ex_jump, ex_reg_write); end
    issue(32'h00100013, 32'h210);
    n_cmp++; if ({ex_valid, ex_reg_write} !== 2'b10) begin n_bad++; $display("FAIL addi_x0 got %b want 10", {ex_valid, ex_reg_write}); end
    issue(32'h0000007F, 32'h214);
    n_cmp++; if ({ex_valid, ex_alu_src, ex_reg_write} !== 3'b000) begin n_bad++; $display("FAIL bad_opcode got %b want 000", {ex_valid, ex_alu_src, ex_reg_write}); end
  endtask
  task automatic test_flush;
    if_instr = 32'h0000A103;
    tick();
    if_instr = 32'h001101B3;
    tick();
    n_cmp++; if (hazard_stall !== 1'b1) begin n_bad++; $display("FAIL fl_pre_stall got %h want 1", hazard_stall); end
    flush = 1'b1;
    if_instr = 32'h00500093;
    #1;
    n_cmp++; if (hazard_stall !== 1'b0) begin n_bad++; $display("FAIL fl_stall_drop got %h want 0", hazard_stall); end
    tick();
    flush = 1'b0;
    if_instr = 32'd0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl_bubble1 got %h want 0", ex_valid); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl_bubble2 got %h want 0", ex_valid); end
  endtask
  task automatic test_rst_mid_stall;
    if_instr = 32'h0000A103;
    tick();
    if_instr = 32'h001101B3;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (hazard_stall !== 1'b0) begin n_bad++; $display("FAIL rs_stall_drop got %h want 0", hazard_stall); end
    tick();
    rst = 1'b0;
    if_instr = 32'd0;
    n_cmp++; if ({ex_valid, ex_rd, ex_mem_read} !== 7'd0) begin n_bad++; $display("FAIL rs_ex_clear got %h %h %h want 0", ex_valid, ex_rd, ex_mem_read); end
    tick();
    n_cmp++; if ({ex_valid, hazard_stall} !== 2'b00) begin n_bad++; $display("FAIL rs_fd_clear got %b want 00", {ex_valid, hazard_stall}); end
  endtask
  task automatic test_regfile;
    wb_we = 1'b1;
    wb_rd = 5'd5;
    wb_data = 32'hDEADBEEF;
    tick();
    wb_rd = 5'd0;
    wb_data = 32'hFFFFFFFF;
    tick();
    wb_we = 1'b0;
    issue(32'h00028333, 32'h300);
    n_cmp++; if ({ex_rs1_data, ex_rs2_data} !== {32'hDEADBEEF, 32'd0}) begin n_bad++; $display("FAIL rf_x5 got %h %h want deadbeef 0", ex_rs1_data, ex_rs2_data); end
    issue(32'h00500333, 32'h304);
    n_cmp++; if ({ex_rs1_data, ex_rs2_data} !== {32'd0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL rf_x0 got %h %h want 0 deadbeef", ex_rs1_data, ex_rs2_data); end
  endtask
  task automatic test_bypass;
    logic [31:0] want;
    wb_we = 1'b1;
    wb_rd = 5'd7;
    wb_data = 32'h1111;
    tick();
    wb_we = 1'b0;
    if_instr = 32'h00038413;
    tick();
    if_instr = 32'd0;
    wb_we = 1'b1;
    wb_data = 32'h1234;
`ifdef ID_RF_BYPASS_EN
    want = 32'h1234;
`else
    want = 32'h1111;
`endif
    tick();
    wb_we = 1'b0;
    n_cmp++; if ({ex_valid, ex_rs1_data} !== {1'b1, want}) begin n_bad++; $display("FAIL bypass got %h %h want 1 %h", ex_valid, ex_rs1_data, want); end
    issue(32'h00038413, 32'h400);
    n_cmp++; if (ex_rs1_data !== 32'h1234) begin n_bad++; $display("FAIL rf_x7_after got %h want 1234", ex_rs1_data); end
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    wb_we = 1'b0;
    wb_rd = 5'd0;
    wb_data = 32'd0;
    if_instr = 32'd0;
    if_pc = 32'd0;
    if_pc_plus4 = 32'd0;
    test_reset();
    test_addi();
    test_load_use();
    test_imm_types();
    test_flush();
    test_rst_mid_stall();
    test_regfile();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
